// File: rtl/load_store_unit.sv
// RV32I load/store bridge to a word-wide, big-endian-lane RAM with no byte mask.
// Sub-word stores are done as read-modify-write; faults are resolved at accept time.
module load_store_unit #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned XLEN   = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [XLEN-1:0]   req_addr_i,
   input  logic [XLEN-1:0]   req_wdata_i,
   output logic              resp_valid_o,
   output logic [XLEN-1:0]   resp_rdata_o,
   output logic              resp_fault_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [XLEN-1:0]   ram_din_o,
   output logic              ram_write_en_o,
   input  logic [XLEN-1:0]   ram_dout_i
);

   typedef enum logic [2:0] {StIdle, StRead, StCapture, StWrite, StResp} state_e;

   state_e            state_q, state_d;
   logic              write_q, write_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        lane_q, lane_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rbuf_q, rbuf_d;
   logic              fault_q, fault_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [XLEN-1:0]   ram_din_q, ram_din_d;

   logic              acc_fault;
   logic [XLEN-1:0]   le_cap, merged, le_buf, shifted, load_val;

   function automatic logic [31:0] swap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   always_comb begin
      acc_fault = 1'b0;
      if (req_addr_i[XLEN-1:ADDR_W] != '0) acc_fault = 1'b1;
      if ((req_funct3_i == 3'd1 || req_funct3_i == 3'd5) && req_addr_i[0]) acc_fault = 1'b1;
      if (req_funct3_i == 3'd2 && req_addr_i[1:0] != 2'b00) acc_fault = 1'b1;
      if (!req_write_i && (req_funct3_i == 3'd3 || req_funct3_i[2:1] == 2'b11)) acc_fault = 1'b1;
      if (req_write_i && req_funct3_i > 3'd2) acc_fault = 1'b1;
   end

   // Merge store data into the little-endian view of the word just read back.
   always_comb begin
      le_cap = swap(ram_dout_i);
      merged = le_cap;
      if (funct3_q[1:0] == 2'b00) begin
         unique case (lane_q)
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (lane_q[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0] = wdata_q[15:0];
      end
   end

   always_comb begin
      le_buf   = swap(rbuf_q);
      shifted  = le_buf >> {lane_q, 3'b000};
      load_val = '0;
      unique case (funct3_q)
         3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'd4:    load_val = {24'd0, shifted[7:0]};
         3'd5:    load_val = {16'd0, shifted[15:0]};
         default: load_val = le_buf;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      funct3_d   = funct3_q;
      lane_d     = lane_q;
      wdata_d    = wdata_q;
      rbuf_d     = rbuf_q;
      fault_d    = fault_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               write_d  = req_write_i;
               funct3_d = req_funct3_i;
               lane_d   = req_addr_i[1:0];
               wdata_d  = req_wdata_i;
               fault_d  = acc_fault;
               if (acc_fault) begin
                  state_d = StResp;
               end else begin
                  ram_addr_d = {req_addr_i[ADDR_W-1:2], 2'b00};
                  if (req_write_i && req_funct3_i == 3'd2) begin
                     ram_din_d = swap(req_wdata_i);
                     state_d   = StWrite;
                  end else begin
                     state_d = StRead;
                  end
               end
            end
         end
         StRead:    state_d = StCapture;
         StCapture: begin
            rbuf_d = ram_dout_i;
            if (write_q) begin
               ram_din_d = swap(merged);
               state_d   = StWrite;
            end else begin
               state_d = StResp;
            end
         end
         StWrite:   state_d = StResp;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         write_q    <= 1'b0;
         funct3_q   <= 3'd0;
         lane_q     <= 2'd0;
         wdata_q    <= '0;
         rbuf_q     <= '0;
         fault_q    <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         funct3_q   <= funct3_d;
         lane_q     <= lane_d;
         wdata_q    <= wdata_d;
         rbuf_q     <= rbuf_d;
         fault_q    <= fault_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
      end
   end

   assign req_ready_o    = (state_q == StIdle);
   assign resp_valid_o   = (state_q == StResp);
   assign resp_fault_o   = resp_valid_o && fault_q;
   assign resp_rdata_o   = (resp_valid_o && !fault_q && !write_q) ? load_val : '0;
   assign ram_addr_o     = ram_addr_q;
   assign ram_din_o      = ram_din_q;
   assign ram_write_en_o = (state_q == StWrite);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference memory, RAM model,
// directed scenarios followed by randomized traffic.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_fault;
   logic [31:0] resp_rdata;
   logic [10:0] ram_addr;
   logic [31:0] ram_din, ram_dout;
   logic        ram_we;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(11), .XLEN(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_fault_o(resp_fault),
      .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_write_en_o(ram_we),
      .ram_dout_i(ram_dout)
   );

   // RAM model: byte addr lands on dout[31:24], read data one edge after the address.
   logic [7:0] ram [0:2047];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2048; i++) ram[i] <= 8'h00;
         ram_dout <= 32'h0;
      end else begin
         if (ram_we) begin
            ram[int'(ram_addr)]     <= ram_din[31:24];
            ram[int'(ram_addr) + 1] <= ram_din[23:16];
            ram[int'(ram_addr) + 2] <= ram_din[15:8];
            ram[int'(ram_addr) + 3] <= ram_din[7:0];
         end
         ram_dout <= {ram[int'(ram_addr)], ram[int'(ram_addr) + 1],
                      ram[int'(ram_addr) + 2], ram[int'(ram_addr) + 3]};
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          lat;
      int          nwr;
      int          acc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] ref_mem [0:2047];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         we_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Reference: plain byte-addressed little-endian memory.
   function automatic exp_t model(input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd);
      exp_t e;
      int   size;
      logic [31:0] v;
      e.fault = (addr >= 32'd2048) || (wr && f3 > 3'd2) ||
                (!wr && (f3 == 3'd3 || f3 >= 3'd6)) ||
                ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) ||
                (f3 == 3'd2 && addr[1:0] != 2'b00);
      e.rdata = 32'h0;
      e.nwr   = 0;
      size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (e.fault) begin
         e.lat = 1;
      end else if (wr) begin
         for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
         e.lat = (size == 4) ? 2 : 4;
         e.nwr = 1;
      end else begin
         v = 32'h0;
         for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
         if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
         if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
         e.rdata = v;
         e.lat   = 3;
      end
      e.acc = 0;
      return e;
   endfunction

   // Called at a negedge; leaves req_valid asserted so requests can go back to back.
   task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
      int   n = 0;
      exp_t e;
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got ready=%b expected 1", req_ready);
         req_valid = 1'b0;
         return;
      end
      e     = model(wr, f3, addr, wd);
      e.acc = cyc + 1;
      @(posedge clk);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle_until_drained();
      int n = 0;
      req_valid = 1'b0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      exp_q.delete();
      for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
      rst = 1'b0;
   endtask

   // Monitor: handshake, response and write-enable checks, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         we_cnt = 0;
      end else begin
         if (ram_we) we_cnt++;
         chk("ram_addr_aligned", {30'd0, ram_addr[1:0]}, 32'd0);
         chk("req_ready", {31'd0, req_ready}, {31'd0, exp_q.size() == 0});
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
            end else begin
               e = exp_q.pop_front();
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
               chk("latency", cyc - e.acc + 1, e.lat);
               chk("write_pulses", we_cnt, e.nwr);
            end
            we_cnt = 0;
         end
      end
   end

   initial begin
      int n;
      logic [31:0] a;
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'h0; req_wdata = 32'h0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
      chk("rst_write_en", {31'd0, ram_we}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_ram_addr", {21'd0, ram_addr}, 32'd0);
      chk("rst_ram_din", ram_din, 32'd0);
      do_reset();
      @(negedge clk);

      issue(1'b1, 3'd2, 32'h100, 32'h1122_3344);
      issue(1'b0, 3'd2, 32'h100, 32'h0);
      idle_until_drained();
      chk("ram_byte_100", {24'd0, ram[32'h100]}, 32'h44);
      chk("ram_byte_103", {24'd0, ram[32'h103]}, 32'h11);

      issue(1'b0, 3'd0, 32'h103, 32'h0);
      issue(1'b0, 3'd1, 32'h102, 32'h0);
      issue(1'b1, 3'd0, 32'h100, 32'h80);
      issue(1'b0, 3'd0, 32'h100, 32'h0);
      issue(1'b0, 3'd4, 32'h100, 32'h0);
      issue(1'b1, 3'd1, 32'h102, 32'hBEEF);
      issue(1'b0, 3'd2, 32'h100, 32'h0);

      issue(1'b0, 3'd2, 32'h101, 32'h0);
      issue(1'b0, 3'd1, 32'h103, 32'h0);
      issue(1'b0, 3'd2, 32'h800, 32'h0);
      issue(1'b0, 3'd3, 32'h100, 32'h0);
      issue(1'b1, 3'd4, 32'h100, 32'h0);

      for (int i = 0; i < 6; i++) issue(1'b1, 3'd2, 32'h200 + 32'(4 * i), $urandom);
      for (int i = 0; i < 6; i++) issue(1'b0, 3'd2, 32'h200 + 32'(4 * i), 32'h0);
      idle_until_drained();

      issue(1'b1, 3'd0, 32'h40, 32'h5A);
      req_valid = 1'b0;
      n = 0;
      while (ram_we !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("sb_reached_write", {31'd0, ram_we}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      exp_q.delete();
      for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      issue(1'b0, 3'd2, 32'h0, 32'h0);
      issue(1'b0, 3'd0, 32'h40, 32'h0);
      idle_until_drained();

      for (int i = 0; i < 300; i++) begin
         n = int'($urandom_range(0, 15));
         if (n == 0)      a = $urandom;
         else if (n < 10) a = 32'h100 + 32'($urandom_range(0, 31));
         else             a = 32'($urandom_range(0, 2047));
         issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
         if ($urandom_range(0, 3) == 0) begin
            req_valid = 1'b0;
            @(negedge clk);
         end
      end
      idle_until_drained();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
